mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): TIMEOUT, 15, maximum cycles spent waiting for m_ack; STARVE_LIMIT, 4, maximum consecutive data grants while fetch waits.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Clk  in  1  single clock, rising edge.
- Clr  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word.
- if_ready  out  1  fetch done, 1-cycle pulse.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data.
- d_ready  out  1  data done, 1-cycle pulse.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data.
- m_ack  in  1  memory done; 1 cycle, any latency of 1 or more cycles.
- stall_if  out  1  holds the fetch stage.
- stall_mem  out  1  holds the memory stage.
- err  out  1  sticky timeout flag.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY_IF and BUSY_D.
REQ-004 In IDLE with at least one eligible request, the block SHALL register the winner's address, write enable and write data onto m_*, and SHALL move to BUSY_IF or BUSY_D on the next edge.
REQ-005 Arbitration SHALL give priority to data over fetch, except that fetch wins when starve_cnt equals STARVE_LIMIT and if_req is high.
REQ-006 starve_cnt SHALL increment on each data grant made while if_req is high, SHALL saturate at STARVE_LIMIT, and SHALL clear on any fetch grant.
REQ-007 m_req SHALL be high exactly while the FSM is in a BUSY state; m_addr, m_we and m_wdata SHALL stay stable for the whole transaction.
REQ-008 For a fetch grant, m_we SHALL be 0 regardless of any other input.
REQ-009 On m_ack in BUSY_x, the block SHALL, on the same edge, capture m_rdata into x_rdata, pulse x_ready for one cycle, and return to IDLE.
REQ-010 Minimum latency SHALL be: request at cycle 0, m_req at cycle 1, ack at cycle 1, ready at cycle 2.
REQ-011 A requester whose ready is high in the current cycle SHALL NOT be eligible for arbitration in that cycle, so a still-high req is not re-granted.
REQ-012 Store completion SHALL pulse d_ready; d_rdata SHALL be left unchanged on a store.
REQ-013 if_rdata and d_rdata SHALL hold their value until the next completion for that requester.
REQ-014 A 4-bit wait counter SHALL clear on entry to BUSY_x and increment each BUSY cycle without m_ack.
REQ-015 When the wait counter reaches TIMEOUT, the block SHALL pulse x_ready with x_rdata = 0, set err, and return to IDLE.
REQ-016 m_ack arriving in IDLE SHALL be ignored.
REQ-017 stall_if SHALL equal if_req & ~if_ready, and stall_mem SHALL equal d_req & ~d_ready, both combinational.
REQ-018 Requesters SHALL hold req and their inputs stable until their ready pulse; changing them earlier has undefined results.

Reset
REQ-019 While Clr is high, the block SHALL set: state IDLE; m_req, m_we, if_ready, d_ready and err to 0; m_addr, m_wdata, if_rdata and d_rdata to 0; starve_cnt and wait counter to 0.
REQ-020 Clr asserted mid-transaction SHALL abandon the transaction with no ready pulse.
REQ-021 After Clr is released, the first arbitration SHALL occur on the first rising edge.
REQ-022 err SHALL be cleared only by Clr.

Structure
REQ-023 The state encoding (IDLE=2'd0, BUSY_IF=2'd1, BUSY_D=2'd2) and the TIMEOUT and STARVE_LIMIT defaults SHALL live in a shared package or include.
REQ-024 Fixed-priority selection with the starvation override SHALL be one combinational sub-module, arb_pick.
REQ-025 The FSM, counters and output registers SHALL be in the top module.

Verification
REQ-026 Fetch only: if_req with if_addr=0x10; memory acks 3 cycles after m_req with m_rdata=0x12345678 -> if_ready pulses once, if_rdata=0x12345678, stall_if is high until the pulse.
REQ-027 Simultaneous requests: if_req and d_req (load, 0x100) in the same cycle -> data is granted first; the fetch is granted in the IDLE cycle after d_ready; no back-to-back re-grant of data.
REQ-028 Starvation: d_req held continuously with if_req high -> after 4 data grants the 5th grant goes to fetch, and starve_cnt returns to 0.
REQ-029 Timeout: m_ack never asserted -> x_ready pulses 15 cycles after m_req rises, x_rdata=0, err=1 and stays set.
REQ-030 Reset mid-operation: Clr asserted during BUSY_D -> outputs at reset values immediately, no d_ready pulse; normal service resumes after Clr is released.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM encoding and default limits for the memory port arbiter
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;
    localparam int DEF_TIMEOUT      = 15;
    localparam int DEF_STARVE_LIMIT = 4;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: fixed data-over-fetch priority with a starvation override for fetch
//   i_if_req / i_d_req : eligible fetch / data requests
//   i_starved          : fetch has lost STARVE_LIMIT consecutive arbitrations
//   o_grant_if / o_grant_d : one-hot (or zero) grant
module arb_pick (
    input  logic i_if_req,
    input  logic i_d_req,
    input  logic i_starved,
    output logic o_grant_if,
    output logic o_grant_d
);
    assign o_grant_if = i_if_req & (~i_d_req | i_starved);
    assign o_grant_d  = i_d_req & ~(i_if_req & i_starved);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch and a data requester
//   Clk, Clr            : clock, async active-high reset
//   if_*                : fetch request / address / returned word / done pulse
//   d_*                 : data request / store flag / address / wdata / load data / done pulse
//   m_*                 : memory-side request, write enable, address, wdata, rdata, ack
//   stall_if, stall_mem : pipeline holds while a request is outstanding
//   err                 : sticky timeout flag
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    state_t        r_state, w_next;
    logic [3:0]    r_wait;
    logic [SW-1:0] r_starve;
    logic          r_if_ready, r_d_ready, r_m_we, r_err;
    logic [31:0]   r_if_rdata, r_d_rdata, r_m_addr, r_m_wdata;
    logic          w_arb_en, w_gnt_if, w_gnt_d, w_busy, w_timeout, w_done;
    // No grant is made in a cycle carrying a ready pulse: the finishing
    // requester is ineligible, and holding off the other one too lets a
    // continuously requesting data port compete again so starvation counts.
    assign w_arb_en  = (r_state == IDLE) & ~r_if_ready & ~r_d_ready;
    assign w_busy    = (r_state == BUSY_IF) | (r_state == BUSY_D);
    assign w_timeout = (r_wait == 4'(TIMEOUT - 1)) & ~m_ack;
    assign w_done    = w_busy & (m_ack | w_timeout);
    arb_pick u_pick (
        .i_if_req   (if_req & w_arb_en),
        .i_d_req    (d_req & w_arb_en),
        .i_starved  (r_starve == SW'(STARVE_LIMIT)),
        .o_grant_if (w_gnt_if),
        .o_grant_d  (w_gnt_d)
    );
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_gnt_if ? BUSY_IF : w_gnt_d ? BUSY_D : IDLE;
            BUSY_IF: w_next = w_done ? IDLE : BUSY_IF;
            BUSY_D:  w_next = w_done ? IDLE : BUSY_D;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state    <= IDLE;
            r_wait     <= '0;
            r_starve   <= '0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_m_we     <= 1'b0;
            r_err      <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
        end else begin
            r_state    <= w_next;
            r_wait     <= w_busy ? r_wait + 4'd1 : '0;
            r_if_ready <= (r_state == BUSY_IF) & w_done;
            r_d_ready  <= (r_state == BUSY_D) & w_done;
            r_err      <= r_err | (w_busy & w_timeout);
            if (r_state == BUSY_IF && w_done)
                r_if_rdata <= m_ack ? m_rdata : '0;
            if (r_state == BUSY_D && w_done && !r_m_we)
                r_d_rdata <= m_ack ? m_rdata : '0;
            if (w_gnt_if || w_gnt_d) begin
                r_m_addr  <= w_gnt_if ? if_addr : d_addr;
                r_m_we    <= w_gnt_d & d_we;
                r_m_wdata <= w_gnt_if ? '0 : d_wdata;
            end
            if (w_gnt_if)
                r_starve <= '0;
            else if (w_gnt_d && if_req && r_starve != SW'(STARVE_LIMIT))
                r_starve <= r_starve + SW'(1);
        end
    end
    assign m_req     = w_busy;
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign d_rdata   = r_d_rdata;
    assign d_ready   = r_d_ready;
    assign err       = r_err;
    assign stall_if  = if_req & ~r_if_ready;
    assign stall_mem = d_req & ~r_d_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        Clk = 1'b0, Clr = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        if_ready, d_ready, m_req, m_we, stall_if, stall_mem, err;
    int          n_chk = 0, n_err = 0;

    mem_port_arbiter dut (
        .Clk(Clk), .Clr(Clr),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_mreq(input string tag);
        int n;
        n = 0;
        while (!m_req && n < 20) begin
            step();
            n++;
        end
        chk(tag, 32'(m_req), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        step();
        step();
        chk("rst_m_req", 32'(m_req), 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_ready", {30'd0, if_ready, d_ready}, 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        // fetch only, ack 3 cycles after m_req; d_we high must not leak into m_we
        Clr = 1'b0; if_req = 1'b1; if_addr = 32'h10; d_we = 1'b1;
        #1 chk("fetch_stall_c0", 32'(stall_if), 1);
        step();
        chk("fetch_m_req_c1", 32'(m_req), 1);
        chk("fetch_m_addr", m_addr, 32'h10);
        chk("fetch_m_we", 32'(m_we), 0);
        step();
        step();
        chk("fetch_stall_c3", 32'(stall_if), 1);
        chk("fetch_ready_c3", 32'(if_ready), 0);
        step();
        chk("fetch_m_addr_stable", m_addr, 32'h10);
        m_ack = 1'b1; m_rdata = 32'h12345678;
        step();
        m_ack = 1'b0;
        chk("fetch_ready", 32'(if_ready), 1);
        chk("fetch_rdata", if_rdata, 32'h12345678);
        chk("fetch_stall_done", 32'(stall_if), 0);
        chk("fetch_m_req_done", 32'(m_req), 0);
        if_req = 1'b0; d_we = 1'b0;
        step();
        chk("fetch_ready_pulse", 32'(if_ready), 0);
        chk("fetch_rdata_hold", if_rdata, 32'h12345678);
        // simultaneous requests: data first, fetch after d_ready
        if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_addr = 32'h100;
        #1 chk("sim_stall_mem", 32'(stall_mem), 1);
        step();
        chk("sim_first_addr", m_addr, 32'h100);
        chk("sim_first_req", 32'(m_req), 1);
        m_ack = 1'b1; m_rdata = 32'hAAAA5555;
        step();
        m_ack = 1'b0;
        chk("sim_d_ready", 32'(d_ready), 1);
        chk("sim_d_rdata", d_rdata, 32'hAAAA5555);
        chk("sim_idle", 32'(m_req), 0);
        d_req = 1'b0;
        step();
        chk("sim_no_regrant", 32'(m_req), 0);
        chk("sim_d_ready_pulse", 32'(d_ready), 0);
        step();
        chk("sim_fetch_req", 32'(m_req), 1);
        chk("sim_fetch_addr", m_addr, 32'h20);
        m_ack = 1'b1; m_rdata = 32'h0BADF00D;
        step();
        m_ack = 1'b0;
        chk("sim_if_ready", 32'(if_ready), 1);
        chk("sim_if_rdata", if_rdata, 32'h0BADF00D);
        if_req = 1'b0;
        step();
        // starvation: four data grants, then fetch
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h200;
        for (int g = 0; g < 4; g++) begin
            wait_mreq("starve_mreq");
            chk("starve_d_addr", m_addr, 32'h200);
            chk("starve_cnt", 32'(dut.r_starve), 32'(g + 1));
            m_ack = 1'b1; m_rdata = 32'h50000000 + 32'(g);
            step();
            m_ack = 1'b0;
            chk("starve_d_ready", 32'(d_ready), 1);
        end
        wait_mreq("starve_mreq5");
        chk("starve_fetch_addr", m_addr, 32'h40);
        chk("starve_cnt_clr", 32'(dut.r_starve), 0);
        m_ack = 1'b1; m_rdata = 32'h50000004;
        step();
        m_ack = 1'b0;
        chk("starve_if_ready", 32'(if_ready), 1);
        chk("starve_if_rdata", if_rdata, 32'h50000004);
        chk("starve_d_rdata", d_rdata, 32'h50000003);
        if_req = 1'b0; d_req = 1'b0;
        step();
        // store: d_ready pulses, d_rdata untouched
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hCAFEF00D;
        step();
        chk("st_m_we", 32'(m_we), 1);
        chk("st_m_wdata", m_wdata, 32'hCAFEF00D);
        chk("st_m_addr", m_addr, 32'h300);
        m_ack = 1'b1; m_rdata = 32'hFFFFFFFF;
        step();
        m_ack = 1'b0;
        chk("st_d_ready", 32'(d_ready), 1);
        chk("st_d_rdata_keep", d_rdata, 32'h50000003);
        d_req = 1'b0; d_we = 1'b0;
        step();
        // timeout: no ack, d_ready 15 cycles after m_req rises
        d_req = 1'b1; d_addr = 32'h400;
        step();
        chk("to_m_req", 32'(m_req), 1);
        repeat (14) step();
        chk("to_early_ready", 32'(d_ready), 0);
        chk("to_still_busy", 32'(m_req), 1);
        step();
        chk("to_d_ready", 32'(d_ready), 1);
        chk("to_d_rdata", d_rdata, 0);
        chk("to_err", 32'(err), 1);
        chk("to_idle", 32'(m_req), 0);
        d_req = 1'b0;
        step();
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        chk("idle_ack_m_req", 32'(m_req), 0);
        chk("idle_ack_ready", {30'd0, if_ready, d_ready}, 0);
        chk("err_sticky", 32'(err), 1);
        // reset during BUSY_D
        d_req = 1'b1; d_addr = 32'h500;
        step();
        chk("rm_busy", 32'(m_req), 1);
        #2 Clr = 1'b1;
        #1;
        chk("rm_m_req", 32'(m_req), 0);
        chk("rm_m_addr", m_addr, 0);
        chk("rm_err", 32'(err), 0);
        chk("rm_rdata", if_rdata | d_rdata, 0);
        d_req = 1'b0;
        step();
        step();
        chk("rm_no_ready", 32'(d_ready), 0);
        Clr = 1'b0; d_req = 1'b1; d_addr = 32'h600;
        step();
        chk("rm_resume_req", 32'(m_req), 1);
        chk("rm_resume_addr", m_addr, 32'h600);
        m_ack = 1'b1; m_rdata = 32'h600D600D;
        step();
        m_ack = 1'b0;
        chk("rm_resume_ready", 32'(d_ready), 1);
        chk("rm_resume_rdata", d_rdata, 32'h600D600D);
        d_req = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
